ram_dp_be: RTL and testbench
============================

# ram_dp_be

Parametrised simple-dual-port RAM with per-lane byte enables, registered read, and a self-sequenced clear after reset. Successor to the single-port combinational-read RAM in the CPU datapath: one write port and one read port operate in the same cycle, so register-file and data-memory users can write and read concurrently without arbitration.

## Interface
- BIT, 16, data word width; must be a multiple of LANE
- SZB, 4, address width; depth SZA = 2**SZB words
- LANE, 8, byte-enable lane width; NLANE = BIT/LANE
- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; starts clear sequence
- we  in  1  write request
- waddr  in  SZB  write address
- wd  in  BIT  write data
- wbe  in  NLANE  lane enables; bit i gates wd[LANE*i +: LANE]
- re  in  1  read request
- raddr  in  SZB  read address
- rq  out  BIT  registered read data
- rvalid  out  1  rq updated this cycle
- busy  out  1  clear sequence in progress; requests ignored
- drop  out  1  sticky: a request arrived while busy

## Operation
- States: CLEAR, READY. Any edge with reset=1: state<=CLEAR, cnt<=0, rq<=0, rvalid<=0, drop<=0. Reset values: busy=1, rq=0, rvalid=0, drop=0.
- CLEAR (reset=0): mem[cnt]<=0, cnt<=cnt+1; at cnt==SZA-1 state<=READY. busy = (state==CLEAR), decoded from state register.
- Reset asserted mid-clear restarts cnt at 0; no partially-cleared state survives.
- In CLEAR, we and re are ignored (no write, rvalid=0); if either is 1, drop<=1. drop clears only on reset.
- READY write: if we, for each lane i with wbe[i]=1, mem[waddr] lane i <= wd lane i; lanes with wbe[i]=0 unchanged. we with wbe=0 is a no-op.
- READY read: if re, rq<=mem[raddr], rvalid<=1; else rvalid<=0 and rq holds previous value.
- Read and write to different addresses in one cycle are independent.
- Read-during-write same address: see Configuration.
- No out-of-range case: addresses cover full depth.

## Timing
- Clear duration: busy high during reset and for exactly SZA cycles after the first edge with reset=0; first accepted request is in cycle SZA after reset release.
- Write latency: data visible to a read issued on the following edge.
- Read latency 1: re sampled at edge N -> rq/rvalid valid after edge N (cycle N+1), rvalid high for one cycle per request.
- Back-to-back reads every cycle supported; throughput one read plus one write per cycle.

## Configuration
- RAM_DP_BYPASS_EN defined: same-address read-during-write returns merged new word (enabled lanes from wd, other lanes from old mem contents).
- Not defined: same-address read-during-write returns the old word (pre-write contents, all lanes).
- Write behaviour and all other timing identical in both builds.

## Structure
- Shared package ram_pkg: state enum (CLEAR, READY), OFF/ON constants, helper for NLANE = BIT/LANE.
- Sub-module ram_dp_clear_seq: state register, cnt, busy, done; RAM top instantiates it and muxes clear writes over user writes.
- Elaboration check: BIT % LANE == 0, else error.

## Test plan
- Reset then release (BIT=16, SZB=4): busy high during reset and 16 cycles after; rq=0, rvalid=0, drop=0; read of every address returns 0x0000.
- Write 0xBEEF to addr 3 wbe=2'b11, next cycle re addr 3 -> rq=0xBEEF, rvalid=1 one cycle later.
- Addr 3=0xBEEF; write 0x1234 wbe=2'b01 -> read returns 0xBE34; wbe=2'b00 write 0xFFFF -> still 0xBE34.
- Same-cycle we/re addr 5 (old 0x0011, wd 0xAABB, wbe=2'b10): bypass build rq=0xAA11; non-bypass rq=0x0011.
- we=1 during clear at cnt=7 -> drop=1 stays high, write discarded (addr reads 0 after clear); reset reasserted at cnt=10 -> busy for full 16 more cycles, drop=0.
- Write addr 2 and read addr 9 same cycle, back-to-back reads of addr 0..15 -> rvalid every cycle, correct data, write lands.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared definitions for the byte-enable dual-port RAM and its clear sequencer.
//   state_e : sequencer state (CLEAR while the array is being zeroed, READY after)
//   OFF/ON  : single-bit constants
//   nlane() : number of byte-enable lanes in a word
package ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    localparam logic OFF = 1'b0;
    localparam logic ON  = 1'b1;

    function automatic int nlane(input int bit_w, input int lane_w);
        return bit_w / lane_w;
    endfunction

endpackage

// File: rtl/ram_dp_clear_seq.sv
// Post-reset clear sequencer. Walks an address counter over the whole array
// once after reset so the RAM can zero one word per cycle.
// Ports:
//   clock   : rising-edge clock
//   reset   : synchronous active-high; restarts the walk at address 0
//   busy_o  : high while the walk is in progress (decoded from the state register)
//   cnt_o   : address currently being cleared
module ram_dp_clear_seq
    import ram_pkg::*;
#(
    parameter int SZB = 4
) (
    input  logic           clock,
    input  logic           reset,
    output logic           busy_o,
    output logic [SZB-1:0] cnt_o
);

    // Last address is all ones because the depth is a power of two.
    localparam logic [SZB-1:0] LAST = '1;

    state_e         state_q, state_d;
    logic [SZB-1:0] cnt_q, cnt_d;
    logic           done;

    assign done = (state_q == CLEAR) && (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (done) begin
                state_d = READY;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o = (state_q == CLEAR);
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/ram_dp_be.sv
// Simple-dual-port RAM with per-lane byte enables, registered read and a
// self-sequenced clear after reset. One write and one read per cycle.
// Build option: define RAM_DP_BYPASS_EN to make a same-address
// read-during-write return the merged new word; otherwise the old word.
// Ports:
//   clock, reset    : clock and synchronous active-high reset (starts clear)
//   we/waddr/wd/wbe : write port; wbe[i] gates lane i of wd
//   re/raddr        : read request
//   rq/rvalid       : registered read data and one-cycle valid
//   busy            : clear in progress, requests ignored
//   drop            : sticky flag, a request arrived while busy
module ram_dp_be
    import ram_pkg::*;
#(
    parameter  int BIT   = 16,
    parameter  int SZB   = 4,
    parameter  int LANE  = 8,
    localparam int NLANE = nlane(BIT, LANE)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [SZB-1:0]   waddr,
    input  logic [BIT-1:0]   wd,
    input  logic [NLANE-1:0] wbe,
    input  logic             re,
    input  logic [SZB-1:0]   raddr,
    output logic [BIT-1:0]   rq,
    output logic             rvalid,
    output logic             busy,
    output logic             drop
);

    localparam int SZA = 2 ** SZB;

    if (BIT % LANE != 0) begin : g_bad_lane
        $error("ram_dp_be: BIT must be a multiple of LANE");
    end

    logic [BIT-1:0]   mem_q [SZA];
    logic [SZB-1:0]   clr_cnt;
    logic             clr_wr;
    logic             acc_wr;
    logic             acc_rd;
    logic [SZB-1:0]   wr_addr;
    logic [BIT-1:0]   wr_data;
    logic [NLANE-1:0] wr_lane;
    logic [BIT-1:0]   rd_word;
    logic [BIT-1:0]   rq_q, rq_d;
    logic             rvalid_q, rvalid_d;
    logic             drop_q, drop_d;

    ram_dp_clear_seq #(
        .SZB(SZB)
    ) u_clear_seq (
        .clock (clock),
        .reset (reset),
        .busy_o(busy),
        .cnt_o (clr_cnt)
    );

    // The sequencer still reports busy while reset is held; only zero the
    // array once reset has been released.
    assign clr_wr = busy & ~reset;
    assign acc_wr = we & ~busy;
    assign acc_rd = re & ~busy;

    // Clear writes own the single write port while busy.
    always_comb begin
        wr_addr = waddr;
        wr_data = wd;
        wr_lane = '0;
        if (clr_wr) begin
            wr_addr = clr_cnt;
            wr_data = '0;
            wr_lane = '1;
        end else if (acc_wr) begin
            wr_lane = wbe;
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NLANE; i++) begin
            if (wr_lane[i]) begin
                mem_q[wr_addr][LANE*i +: LANE] <= wr_data[LANE*i +: LANE];
            end
        end
    end

    always_comb begin
        rd_word = mem_q[raddr];
`ifdef RAM_DP_BYPASS_EN
        // Forward enabled lanes of a same-cycle write to the same address.
        if (acc_wr && (waddr == raddr)) begin
            for (int i = 0; i < NLANE; i++) begin
                if (wbe[i]) begin
                    rd_word[LANE*i +: LANE] = wd[LANE*i +: LANE];
                end
            end
        end
`endif
    end

    always_comb begin
        rq_d     = acc_rd ? rd_word : rq_q;
        rvalid_d = acc_rd;
        drop_d   = drop_q | (busy & (we | re));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rq_q     <= '0;
            rvalid_q <= OFF;
            drop_q   <= OFF;
        end else begin
            rq_q     <= rq_d;
            rvalid_q <= rvalid_d;
            drop_q   <= drop_d;
        end
    end

    assign rq     = rq_q;
    assign rvalid = rvalid_q;
    assign drop   = drop_q;

endmodule

// File: tb/tb_ram_dp_be.sv
// Scoreboard bench for ram_dp_be (BIT=16, SZB=4, LANE=8).
module tb_ram_dp_be;

    localparam int BIT  = 16;
    localparam int SZB  = 4;
    localparam int LANE = 8;
    localparam int SZA  = 16;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             we    = 1'b0;
    logic [SZB-1:0]   waddr = '0;
    logic [BIT-1:0]   wd    = '0;
    logic [1:0]       wbe   = '0;
    logic             re    = 1'b0;
    logic [SZB-1:0]   raddr = '0;
    logic [BIT-1:0]   rq;
    logic             rvalid;
    logic             busy;
    logic             drop;

    ram_dp_be #(.BIT(BIT), .SZB(SZB), .LANE(LANE)) dut (
        .clock (clock),
        .reset (reset),
        .we    (we),
        .waddr (waddr),
        .wd    (wd),
        .wbe   (wbe),
        .re    (re),
        .raddr (raddr),
        .rq    (rq),
        .rvalid(rvalid),
        .busy  (busy),
        .drop  (drop)
    );

    always #5 clock = ~clock;

    // Reference model state
    logic [BIT-1:0] ref_mem [SZA];
    bit             mdl_ready = 0;
    int             clr_done  = 0;
    bit             mdl_drop  = 0;
    logic [BIT-1:0] mdl_rq    = '0;
    logic [BIT-1:0] exp_q [$];
    bit             mon_en    = 0;

    int errors = 0;
    int checks = 0;

    function automatic logic [BIT-1:0] merge(input logic [BIT-1:0] old_w,
                                             input logic [BIT-1:0] new_w,
                                             input logic [1:0] be);
        logic [BIT-1:0] r;
        r = old_w;
        if (be[0]) r[7:0]  = new_w[7:0];
        if (be[1]) r[15:8] = new_w[15:8];
        return r;
    endfunction

    task automatic check(input string name, input logic [BIT-1:0] act, input logic [BIT-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Applies one cycle of stimulus and advances the model for the coming edge.
    task automatic drive(input logic r, input logic w, input logic [3:0] wa,
                         input logic [15:0] d, input logic [1:0] be,
                         input logic rd, input logic [3:0] ra);
        logic [BIT-1:0] word;
        @(negedge clock);
        #1;
        reset = r; we = w; waddr = wa; wd = d; wbe = be; re = rd; raddr = ra;
        if (r) begin
            mdl_ready = 0;
            clr_done  = 0;
            mdl_drop  = 0;
            mdl_rq    = '0;
            exp_q.delete();
            mon_en    = 1;
        end else if (!mdl_ready) begin
            if (w || rd) mdl_drop = 1;
            ref_mem[clr_done] = '0;
            clr_done++;
            if (clr_done == SZA) mdl_ready = 1;
        end else begin
            if (rd) begin
                word = ref_mem[ra];
`ifdef RAM_DP_BYPASS_EN
                if (w && wa == ra) word = merge(word, d, be);
`endif
                exp_q.push_back(word);
                mdl_rq = word;
            end
            if (w) ref_mem[wa] = merge(ref_mem[wa], d, be);
        end
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
        drive(0, 1, a, d, be, 0, 0);
    endtask

    task automatic rdq(input logic [3:0] a);
        drive(0, 0, 0, 0, 0, 1, a);
    endtask

    // Monitor: compares the DUT against the model after every edge.
    always @(negedge clock) begin
        if (mon_en) begin
            check("busy", {15'd0, busy}, {15'd0, !mdl_ready});
            check("drop", {15'd0, drop}, {15'd0, mdl_drop});
            if (exp_q.size() > 0) begin
                check("rvalid_hi", {15'd0, rvalid}, 16'd1);
                check("rq_data", rq, exp_q.pop_front());
            end else begin
                check("rvalid_lo", {15'd0, rvalid}, 16'd0);
                check("rq_hold", rq, mdl_rq);
            end
        end
    end

    task automatic wait_clear(input string name, input int exp_busy);
        int nb;
        bit ok;
        nb = 0;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            idle();
            if (busy) nb++;
            else begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok || nb != exp_busy) begin
            errors++;
            $display("FAIL %s: busy cycles %0d expected %0d (ended=%0d)", name, nb, exp_busy, ok);
        end
    endtask

    initial begin
        // Power-up reset, then clear sequence
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        wait_clear("clear_len", SZA);

        // Every address reads zero after clear
        for (int a = 0; a < SZA; a++) rdq(a[3:0]);

        // Full write then read-back
        wr(3, 16'hBEEF, 2'b11);
        rdq(3);
        // Partial lane write, then disabled-lane write
        wr(3, 16'h1234, 2'b01);
        rdq(3);
        wr(3, 16'hFFFF, 2'b00);
        rdq(3);

        // Same-address read-during-write
        wr(5, 16'h0011, 2'b11);
        drive(0, 1, 5, 16'hAABB, 2'b10, 1, 5);
        rdq(5);

        // Independent write/read, then back-to-back reads
        wr(9, 16'h5A5A, 2'b11);
        drive(0, 1, 2, 16'hC3D4, 2'b11, 1, 9);
        for (int a = 0; a < SZA; a++) rdq(a[3:0]);

        // Randomised traffic, narrow address range half the time for collisions
        for (int n = 0; n < 400; n++) begin
            logic [3:0] wa, ra;
            bit narrow;
            narrow = ($urandom_range(0, 1) == 1);
            wa = narrow ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            ra = narrow ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            drive(0, 1'($urandom_range(0, 1)), wa, 16'($urandom), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), ra);
        end
        idle();

        // Request during clear sets drop; reset mid-clear restarts the walk
        wr(4, 16'h7777, 2'b11);
        drive(1, 0, 0, 0, 0, 0, 0);
        while (clr_done < 7) idle();
        drive(0, 1, 4, 16'hDEAD, 2'b11, 0, 0);
        while (clr_done < 10) idle();
        drive(1, 0, 0, 0, 0, 0, 0);
        wait_clear("clear_restart", SZA);
        rdq(4);
        rdq(0);
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
